rv_fetch_unit: RTL and testbench

- Parametrised instruction-fetch stage for the single-cycle/pipelined RV32I cores; successor of the bare PC + PC-adder + instruction-memory hookup.
- Owns the PC and issues word fetches to a synchronous instruction memory with fixed 1-cycle read latency.
- Buffers returned instructions in a small FIFO and presents them to decode over a valid/ready handshake.
- Accepts branch/jump redirects, flushing in-flight and buffered wrong-path instructions, and flags misaligned targets.

---
 rtl/rv_fetch_pkg.sv | 18 +
 rtl/rv_fetch_fifo.sv | 49 ++++
 rtl/rv_fetch_unit.sv | 130 +++++++++++++
 tb/tb_rv_fetch_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared definitions for the RV32I instruction-fetch stage: FSM encoding,
// instruction width, PC step and the word-alignment mask.
package rv_fetch_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  localparam int         INSTR_W    = 32;
  localparam int         PC_INC     = 4;
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  function automatic logic is_misaligned(input logic [1:0] lsbs);
    return (lsbs & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/rv_fetch_fifo.sv
// Synchronous instruction buffer with a flush that empties it at the clock edge.
// DEPTH must be a power of two so the pointers wrap without extra logic.
module rv_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // NOTE: the storage array is deliberately not reset; validity is tracked
  // by count_q alone, which keeps the array as plain RAM/flops without reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wdata;
  end

  assign rdata = mem[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/rv_fetch_unit.sv
// RV32I fetch stage: owns the PC, issues 1-cycle-latency word fetches, buffers
// responses and hands them to decode. Optional counters under RV_FETCH_PERF_EN.
module rv_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_instr,
  output logic [XLEN-1:0]    out_pc,
  output logic               fetch_fault
`ifdef RV_FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall
`endif
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W   = CNT_W + 1;
  localparam int ENTRY_W = INSTR_W + XLEN;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, req_pc_q;
  logic            inflight_q, fault_q, fault_d;

  logic               fifo_push, fifo_pop, fifo_flush, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] fifo_wdata, fifo_rdata;
  logic               redir_ok, redir_bad;
  logic [OCC_W-1:0]   occupancy;

  assign redir_ok  = redirect_valid && !is_misaligned(redirect_target[1:0]);
  assign redir_bad = redirect_valid &&  is_misaligned(redirect_target[1:0]);

  // A redirect of either kind kills the in-flight response and flushes the buffer.
  assign out_valid  = !rst && !fifo_empty;
  assign fifo_pop   = out_valid && out_ready;
  assign fifo_push  = !rst && inflight_q && !redirect_valid;
  assign fifo_flush = redirect_valid;
  assign fifo_wdata = {imem_rdata, req_pc_q};
  assign {out_instr, out_pc} = fifo_rdata;
  assign fetch_fault = !rst && fault_q;

  // Slots committed after this cycle: buffered + returning - leaving.
  assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight_q) - OCC_W'(fifo_pop);

  rv_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (fifo_flush),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the branches below can leave one unassigned and infer a latch.
    state_d   = state_q;
    fault_d   = fault_q;
    pc_d      = pc_q;
    imem_req  = 1'b0;
    imem_addr = pc_q;
    if (!rst) begin
      if (redir_ok) begin
        imem_req  = 1'b1;
        imem_addr = redirect_target;
        state_d   = ST_RUN;
        fault_d   = 1'b0;
      end else if (redir_bad) begin
        state_d = ST_HALT;
        fault_d = 1'b1;
      end else begin
        unique case (state_q)
          ST_RUN:  imem_req = (occupancy < OCC_W'(FIFO_DEPTH));
          ST_HALT: imem_req = 1'b0;
          default: imem_req = 1'b0;
        endcase
      end
      if (imem_req) pc_d = imem_addr + XLEN'(PC_INC);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= imem_req;
      fault_q    <= fault_d;
      if (imem_req) req_pc_q <= imem_addr;
    end
  end

`ifdef RV_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (fifo_push) perf_fetched <= perf_fetched + 32'd1;
      if (state_q == ST_RUN && !imem_req && !redirect_valid)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Self-checking bench for rv_fetch_unit: directed scenarios with literal
// expectations plus a randomized run against a queue-based delivery model.
module tb_rv_fetch_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            imem_req, out_valid, out_ready, fetch_fault, redirect_valid;
  logic [31:0]     imem_addr, imem_rdata, out_instr, out_pc, redirect_target;

  logic            w_imem_req, w_out_valid, w_fetch_fault;
  logic [31:0]     w_imem_addr, w_imem_rdata, w_out_instr, w_out_pc;
  logic            w_out_ready = 1'b1;
  logic            w_redirect_valid = 1'b0;
  logic [31:0]     w_redirect_target = 32'h0;

`ifdef RV_FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall, w_perf_fetched, w_perf_stall;
`endif

  rv_fetch_unit #(.XLEN(XLEN), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .fetch_fault(fetch_fault)
`ifdef RV_FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  rv_fetch_unit #(.XLEN(XLEN), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)) dut_wrap (
    .clk(clk), .rst(rst), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_rdata(w_imem_rdata), .redirect_valid(w_redirect_valid),
    .redirect_target(w_redirect_target), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .out_instr(w_out_instr), .out_pc(w_out_pc),
    .fetch_fault(w_fetch_fault)
`ifdef RV_FETCH_PERF_EN
    , .perf_fetched(w_perf_fetched), .perf_stall(w_perf_stall)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction word tagged by its address so misrouted words are detectable.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC001_D00D;
  endfunction

  // Memories with one-cycle latency; idle cycles return noise.
  always @(posedge clk) begin
    imem_rdata   <= imem_req   ? word_of(imem_addr)   : $urandom;
    w_imem_rdata <= w_imem_req ? word_of(w_imem_addr) : $urandom;
  end

  // Reference model: the buffer as a queue of PCs, one optional PC in flight.
  logic [31:0] m_q[$];
  bit          m_infl = 1'b0;
  logic [31:0] m_infl_pc = 32'h0;
  logic [31:0] m_next_pc = 32'h0;
  bit          m_halt = 1'b0;
  bit          m_fault = 1'b0;
  bit          e_valid, e_req, e_fault, e_pop;
  logic [31:0] e_addr;
  int          e_occ;

  always @(negedge clk) begin
    e_valid = 1'b0; e_req = 1'b0; e_fault = 1'b0; e_pop = 1'b0; e_addr = 32'h0;
    if (!rst) begin
      e_valid = (m_q.size() != 0);
      e_fault = m_fault;
      e_pop   = e_valid && out_ready;
      e_occ   = m_q.size() + int'(m_infl) - int'(e_pop);
      if (redirect_valid && redirect_target[1:0] == 2'b00) begin
        e_req  = 1'b1;
        e_addr = redirect_target;
      end else if (!redirect_valid && !m_halt) begin
        e_req  = (e_occ < DEPTH);
        e_addr = m_next_pc;
      end
    end

    check("out_valid", out_valid, e_valid);
    check("imem_req", imem_req, e_req);
    check("fetch_fault", fetch_fault, e_fault);
    if (e_valid) begin
      check("out_pc", out_pc, m_q[0]);
      check("out_instr", out_instr, word_of(m_q[0]));
    end
    if (e_req) check("imem_addr", imem_addr, e_addr);

    if (rst) begin
      m_q.delete();
      m_infl = 1'b0; m_next_pc = 32'h0; m_halt = 1'b0; m_fault = 1'b0;
    end else begin
      if (e_pop) void'(m_q.pop_front());
      if (redirect_valid) m_q.delete();
      else if (m_infl) m_q.push_back(m_infl_pc);
      m_infl = e_req;
      if (e_req) begin
        m_infl_pc = e_addr;
        m_next_pc = e_addr + 32'd4;
      end
      if (redirect_valid) begin
        m_halt  = (redirect_target[1:0] != 2'b00);
        m_fault = m_halt;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;

    // Reset held: outputs quiet.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_fault", fetch_fault, 1'b0);

    // Release: request in cycle 0, data from cycle 2, one per cycle.
    next_cycle(); rst = 1'b0;
    @(negedge clk);
    check("c0_req", imem_req, 1'b1);
    check("c0_addr", imem_addr, 32'h0);
    @(negedge clk);
    check("c1_valid", out_valid, 1'b0);
    @(negedge clk);
    check("c2_valid", out_valid, 1'b1);
    check("c2_pc", out_pc, 32'h0);
    check("wrap_c2_pc", w_out_pc, 32'hFFFF_FFF8);
    check("wrap_c2_instr", w_out_instr, 32'hFFFF_FFF8 ^ 32'hC001_D00D);
    @(negedge clk);
    check("c3_pc", out_pc, 32'h4);
    check("wrap_c3_pc", w_out_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    check("c4_pc", out_pc, 32'h8);
    check("wrap_c4_pc", w_out_pc, 32'h0);

    // Back-pressure from the first fetch: two entries buffered, requests stop.
    next_cycle(); rst = 1'b1; out_ready = 1'b0;
    next_cycle(); rst = 1'b0;
    repeat (10) @(negedge clk);
    check("stall_valid", out_valid, 1'b1);
    check("stall_pc", out_pc, 32'h0);
    check("stall_req", imem_req, 1'b0);
    next_cycle(); out_ready = 1'b1;
    @(negedge clk);
    check("resume_addr", imem_addr, 32'h8);
    check("resume_pc", out_pc, 32'h0);

    // Aligned redirect two cycles later: wrong-path 0xC never delivered.
    next_cycle();
    next_cycle(); redirect_valid = 1'b1; redirect_target = 32'h100;
    @(negedge clk);
    check("redir_req", imem_req, 1'b1);
    check("redir_addr", imem_addr, 32'h100);
    next_cycle(); redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_gap", out_valid, 1'b0);
    @(negedge clk);
    check("redir_pc0", out_pc, 32'h100);
    @(negedge clk);
    check("redir_pc1", out_pc, 32'h104);

    // Misaligned redirect halts; aligned redirect recovers.
    next_cycle(); redirect_valid = 1'b1; redirect_target = 32'h102;
    @(negedge clk);
    check("mis_req", imem_req, 1'b0);
    next_cycle(); redirect_valid = 1'b0;
    @(negedge clk);
    check("halt_fault", fetch_fault, 1'b1);
    check("halt_valid", out_valid, 1'b0);
    check("halt_req", imem_req, 1'b0);
    next_cycle(); redirect_valid = 1'b1; redirect_target = 32'h200;
    @(negedge clk);
    check("recover_addr", imem_addr, 32'h200);
    next_cycle(); redirect_valid = 1'b0;
    @(negedge clk);
    check("recover_fault", fetch_fault, 1'b0);
    @(negedge clk);
    check("recover_pc", out_pc, 32'h200);

    // One-cycle reset mid-stream with a request in flight.
    next_cycle(); rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", out_valid, 1'b0);
    next_cycle(); rst = 1'b0;
    @(negedge clk);
    check("mid_rst_addr", imem_addr, 32'h0);
    @(negedge clk);
    check("mid_rst_stale", out_valid, 1'b0);
    @(negedge clk);
    check("mid_rst_pc", out_pc, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      next_cycle();
      rst       = ($urandom_range(0, 199) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_target = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) == 0) redirect_target = 32'hFFFF_FFF0 | ($urandom & 32'hC);
      if ($urandom_range(0, 3) == 0) redirect_target[1:0] = 2'($urandom_range(1, 3));
    end
    next_cycle();
    rst = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
